// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, the latched request
// record and the address range check.
package dmem_pkg;

    localparam int MEM_BYTES_DEF    = 4096;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_CORE,
        ST_BUSY_LD,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic        is_byte;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Last touched byte is computed in 33 bits so a word near 0xFFFFFFFF
    // cannot wrap back into the legal range.
    function automatic logic range_err(input logic [31:0] addr,
                                       input logic        is_byte,
                                       input int unsigned mem_bytes);
        logic [32:0] last;
        last = {1'b0, addr} + (is_byte ? 33'd0 : 33'd3);
        return last >= 33'(mem_bytes);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory port of the arbiter.
// slave is the arbiter side, master is the requesters/memory side.
interface dmem_arbiter_if;

    logic        core_req;
    logic        core_we;
    logic        core_byte;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;

    logic        ld_req;
    logic        ld_we;
    logic        ld_byte;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ld_err;

    logic        mem_read;
    logic        mem_write;
    logic        load_byte;
    logic        store_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_byte, core_addr, core_wdata,
        input  ld_req, ld_we, ld_byte, ld_addr, ld_wdata,
        input  mem_rdata,
        output core_gnt, core_rvalid, core_rdata, core_err,
        output ld_gnt, ld_rvalid, ld_rdata, ld_err,
        output mem_read, mem_write, load_byte, store_byte, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_byte, core_addr, core_wdata,
        output ld_req, ld_we, ld_byte, ld_addr, ld_wdata,
        output mem_rdata,
        input  core_gnt, core_rvalid, core_rdata, core_err,
        input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
        input  mem_read, mem_write, load_byte, store_byte, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_prio_sel.sv
// Fixed core priority with a starvation bound: after STARVE_LIMIT lost
// arbitrations the loader is given one win.
module dmem_prio_sel
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic decide,
    input  logic core_req,
    input  logic ld_req,
    output logic sel_ld
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign sel_ld = ld_req && ((starve_cnt == CNT_MAX) || !core_req);

    // Count loader losses on each IDLE decision, clear when the loader wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (decide) begin
            if (sel_ld) begin
                starve_cnt <= '0;
            end else if (ld_req && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one byte-addressed data memory between the core LSU and the
// program/debug loader. One access per 3 cycles: IDLE -> BUSY -> RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES    = MEM_BYTES_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    state_t      state_q, state_d;
    logic        sel_ld;
    logic        any_req;
    logic        decide;
    logic        busy;
    logic        access_ok;

    req_t        req_p0;
    logic        err_p0;
    logic        owner_ld_p0;

    logic        resp_err_p1;
    logic [31:0] resp_data_d;
    logic [31:0] core_rdata_p1;
    logic [31:0] ld_rdata_p1;

    assign any_req   = bus.core_req || bus.ld_req;
    assign decide    = (state_q == ST_IDLE) && any_req;
    assign busy      = (state_q == ST_BUSY_CORE) || (state_q == ST_BUSY_LD);
    assign access_ok = busy && !err_p0;

    dmem_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .decide   (decide),
        .core_req (bus.core_req),
        .ld_req   (bus.ld_req),
        .sel_ld   (sel_ld)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a request seen during RESP waits for IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (any_req) state_d = sel_ld ? ST_BUSY_LD : ST_BUSY_CORE;
            ST_BUSY_CORE: state_d = ST_RESP;
            ST_BUSY_LD:   state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // ---- p0: winning request latched at the IDLE decision ----
    // Capture the winner's fields and its range check.
    always_ff @(posedge clk) begin
        if (decide) begin
            req_p0      <= sel_ld
                           ? '{we: bus.ld_we,   is_byte: bus.ld_byte,
                               addr: bus.ld_addr,   wdata: bus.ld_wdata}
                           : '{we: bus.core_we, is_byte: bus.core_byte,
                               addr: bus.core_addr, wdata: bus.core_wdata};
            err_p0      <= sel_ld
                           ? range_err(bus.ld_addr,   bus.ld_byte,   MEM_BYTES)
                           : range_err(bus.core_addr, bus.core_byte, MEM_BYTES);
            owner_ld_p0 <= sel_ld;
        end
    end

    // Stores and rejected accesses return zero data.
    always_comb resp_data_d = (err_p0 || req_p0.we) ? 32'h0 : bus.mem_rdata;

    // ---- p1: response captured at the end of BUSY ----
    // Only the owner's rdata register updates; the other holds its value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_err_p1   <= 1'b0;
            core_rdata_p1 <= 32'h0;
            ld_rdata_p1   <= 32'h0;
        end else if (busy) begin
            resp_err_p1 <= err_p0;
            if (owner_ld_p0) begin
                ld_rdata_p1   <= resp_data_d;
            end else begin
                core_rdata_p1 <= resp_data_d;
            end
        end
    end

    // Memory controls only during a legal BUSY; rst_n gates read/write so a
    // reset cycle can never commit a store.
    always_comb begin
        bus.mem_read    = access_ok && !req_p0.we && rst_n;
        bus.mem_write   = access_ok &&  req_p0.we && rst_n;
        bus.load_byte   = access_ok && req_p0.is_byte && !req_p0.we;
        bus.store_byte  = access_ok && req_p0.is_byte &&  req_p0.we;
        bus.mem_addr    = access_ok ? req_p0.addr  : 32'h0;
        bus.mem_wdata   = access_ok ? req_p0.wdata : 32'h0;
        bus.core_gnt    = (state_q == ST_BUSY_CORE);
        bus.ld_gnt      = (state_q == ST_BUSY_LD);
        bus.core_rvalid = (state_q == ST_RESP) && !owner_ld_p0;
        bus.ld_rvalid   = (state_q == ST_RESP) &&  owner_ld_p0;
        bus.core_err    = bus.core_rvalid && resp_err_p1;
        bus.ld_err      = bus.ld_rvalid   && resp_err_p1;
        bus.core_rdata  = core_rdata_p1;
        bus.ld_rdata    = ld_rdata_p1;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected grants
// and responses; a negedge monitor pops and compares whatever the DUT emits.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .MEM_BYTES    (4096),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t core_q[$];
    resp_t ld_q[$];
    logic  exp_gnt_q[$];   // 0 = core, 1 = loader

    logic core_gnt_prev = 1'b0;
    logic ld_gnt_prev   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event outside expectation", name);
    endtask

    // Byte memory model, little-endian, byte loads sign-extended.
    logic [7:0] mem [0:4095] = '{default: 8'h00};

    function automatic int ix(input logic [31:0] a, input int k);
        logic [31:0] s;
        s = a + 32'(k);
        return int'(s[11:0]);
    endfunction

    always_comb begin
        bus.mem_rdata = 32'h0;
        if (bus.load_byte) begin
            bus.mem_rdata = {{24{mem[ix(bus.mem_addr, 0)][7]}}, mem[ix(bus.mem_addr, 0)]};
        end else begin
            bus.mem_rdata = {mem[ix(bus.mem_addr, 3)], mem[ix(bus.mem_addr, 2)],
                             mem[ix(bus.mem_addr, 1)], mem[ix(bus.mem_addr, 0)]};
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            if (bus.store_byte) begin
                mem[ix(bus.mem_addr, 0)] <= bus.mem_wdata[7:0];
            end else begin
                mem[ix(bus.mem_addr, 0)] <= bus.mem_wdata[7:0];
                mem[ix(bus.mem_addr, 1)] <= bus.mem_wdata[15:8];
                mem[ix(bus.mem_addr, 2)] <= bus.mem_wdata[23:16];
                mem[ix(bus.mem_addr, 3)] <= bus.mem_wdata[31:24];
            end
        end
    end

    // Monitor: grant order, gnt->rvalid spacing and response contents.
    always @(negedge clk) begin
        if (!rst_n) begin
            core_gnt_prev <= 1'b0;
            ld_gnt_prev   <= 1'b0;
        end else begin
            if (bus.core_gnt || bus.ld_gnt) begin
                chk1("gnt_exclusive", bus.core_gnt && bus.ld_gnt, 1'b0);
                if (exp_gnt_q.size() == 0) fail_now("unexpected_gnt");
                else chk1("gnt_owner_is_ld", bus.ld_gnt, exp_gnt_q.pop_front());
            end
            if (core_gnt_prev || bus.core_rvalid)
                chk1("core_rvalid_after_gnt", bus.core_rvalid, core_gnt_prev);
            if (ld_gnt_prev || bus.ld_rvalid)
                chk1("ld_rvalid_after_gnt", bus.ld_rvalid, ld_gnt_prev);
            if (bus.core_rvalid) begin
                if (core_q.size() == 0) fail_now("core_unexpected_rvalid");
                else begin
                    chk("core_rdata", bus.core_rdata, core_q[0].rdata);
                    chk1("core_err", bus.core_err, core_q[0].err);
                    void'(core_q.pop_front());
                end
            end
            if (bus.ld_rvalid) begin
                if (ld_q.size() == 0) fail_now("ld_unexpected_rvalid");
                else begin
                    chk("ld_rdata", bus.ld_rdata, ld_q[0].rdata);
                    chk1("ld_err", bus.ld_err, ld_q[0].err);
                    void'(ld_q.pop_front());
                end
            end
            core_gnt_prev <= bus.core_gnt;
            ld_gnt_prev   <= bus.ld_gnt;
        end
    end

    task automatic set_req(input logic is_ld, input logic req, input logic we, input logic byt,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (is_ld) begin
            bus.ld_req = req; bus.ld_we = we; bus.ld_byte = byt;
            bus.ld_addr = addr; bus.ld_wdata = wdata;
        end else begin
            bus.core_req = req; bus.core_we = we; bus.core_byte = byt;
            bus.core_addr = addr; bus.core_wdata = wdata;
        end
    endtask

    // One access; hold = extra cycles req stays high after gnt (into RESP).
    task automatic access(input logic is_ld, input logic we, input logic byt,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        logic got;
        got = 1'b0;
        exp_gnt_q.push_back(is_ld);
        if (is_ld) ld_q.push_back('{exp_rdata, exp_err});
        else       core_q.push_back('{exp_rdata, exp_err});
        set_req(is_ld, 1'b1, we, byt, addr, wdata);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = is_ld ? bus.ld_gnt : bus.core_gnt;
        end
        if (!got) begin
            fail_now("gnt_timeout");
            set_req(is_ld, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            return;
        end
        if (exp_err) begin
            chk1("err_no_mem_read", bus.mem_read, 1'b0);
            chk1("err_no_mem_write", bus.mem_write, 1'b0);
        end else begin
            chk("busy_mem_addr", bus.mem_addr, addr);
        end
        repeat (1 + hold) @(posedge clk);
        #1;
        set_req(is_ld, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_core_gnt"}, bus.core_gnt, 1'b0);
        chk1({tag, "_ld_gnt"}, bus.ld_gnt, 1'b0);
        chk1({tag, "_core_rvalid"}, bus.core_rvalid, 1'b0);
        chk1({tag, "_ld_rvalid"}, bus.ld_rvalid, 1'b0);
        chk1({tag, "_core_err"}, bus.core_err, 1'b0);
        chk1({tag, "_ld_err"}, bus.ld_err, 1'b0);
        chk({tag, "_core_rdata"}, bus.core_rdata, 32'h0);
        chk({tag, "_ld_rdata"}, bus.ld_rdata, 32'h0);
        chk1({tag, "_mem_read"}, bus.mem_read, 1'b0);
        chk1({tag, "_mem_write"}, bus.mem_write, 1'b0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngnt;
        logic got;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store then load back; loader byte store then core lb.
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        access(1'b1, 1'b1, 1'b1, 32'h20, 32'h00000080, 32'h0, 1'b0, 0);
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 0);

        // Range boundaries.
        access(1'b0, 1'b0, 1'b0, 32'hFFD, 32'h0, 32'h0, 1'b1, 0);
        access(1'b0, 1'b1, 1'b1, 32'hFFF, 32'h0000007F, 32'h0, 1'b0, 0);
        access(1'b0, 1'b0, 1'b1, 32'hFFF, 32'h0, 32'h0000007F, 1'b0, 0);
        access(1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 0);
        access(1'b1, 1'b0, 1'b0, 32'hFFC, 32'h0, 32'h7F000000, 1'b0, 0);

        // Request held through RESP is a single access.
        access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);

        // Reset while a store is in BUSY: no commit, no response.
        exp_gnt_q.push_back(1'b0);
        set_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h11223344);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.core_gnt;
        end
        chk1("rst_busy_gnt_seen", got, 1'b1);
        #1;
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("rst_busy_mem_write", bus.mem_write, 1'b0);
        @(posedge clk); #1;
        chk_all_zero("rst_mid");
        chk({"rst_mem_word"}, {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 0);

        // Both requesters held: core x4, loader, core x4, loader.
        for (int i = 0; i < 10; i++) begin
            exp_gnt_q.push_back(i == 4 || i == 9);
            if (i == 4 || i == 9) ld_q.push_back('{32'h00000080, 1'b0});
            else                  core_q.push_back('{32'hDEADBEEF, 1'b0});
        end
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        ngnt = 0;
        for (int i = 0; i < 100 && ngnt < 10; i++) begin
            @(negedge clk);
            if (bus.core_gnt || bus.ld_gnt) ngnt++;
        end
        chk("starve_gnt_count", 32'(ngnt), 32'd10);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        chk("core_q_drained", 32'(core_q.size()), 32'd0);
        chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
        chk("gnt_q_drained", 32'(exp_gnt_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single byte-addressed data memory between the core load/store unit and the program/debug loader. It sits between both requesters and the data memory's `mem_read`/`mem_write`/`load_byte`/`store_byte`/`addr`/`write_data`/`read_data` port, registers each winning request, performs the access in one memory cycle and returns a registered response. Priority is fixed to the core, with a starvation bound for the loader, and out-of-range accesses are rejected without touching memory.

## Interface
- `MEM_BYTES`, 4096: data memory size in bytes; legal word access needs `addr + 3 < MEM_BYTES`, legal byte access needs `addr < MEM_BYTES`.
- `STARVE_LIMIT`, 4: consecutive lost arbitrations after which the loader wins once.
- `clk` in 1: single clock; everything on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `core_req`, `ld_req` in 1: request; fields held stable until grant.
- `core_we`, `ld_we` in 1: 1 = store, 0 = load.
- `core_byte`, `ld_byte` in 1: 1 = byte (sb/lb), 0 = word.
- `core_addr`, `ld_addr` in 32: byte address.
- `core_wdata`, `ld_wdata` in 32: store data.
- `core_gnt`, `ld_gnt` out 1: one-cycle pulse, request accepted.
- `core_rvalid`, `ld_rvalid` out 1: one-cycle pulse, response valid (loads and stores).
- `core_rdata`, `ld_rdata` out 32: load data; 0 for stores and errors.
- `core_err`, `ld_err` out 1: qualifies rvalid; out-of-range access.
- `mem_read`, `mem_write`, `load_byte`, `store_byte` out 1: memory controls.
- `mem_addr`, `mem_wdata` out 32: memory address/data.
- `mem_rdata` in 32: memory read data (combinational).

## Operation
- FSM: IDLE, BUSY_CORE, BUSY_LD, RESP.
- IDLE with any req: pick winner, latch `we`, `byte`, `addr`, `wdata` into a request register, compute range error, pulse winner's gnt next cycle, go to BUSY_x.
- Winner: loader if `starve_cnt == STARVE_LIMIT` and `ld_req`; else core if `core_req`; else loader.
- `starve_cnt` (width clog2(STARVE_LIMIT+1)): +1 on each IDLE decision where `ld_req` and core wins; cleared when loader is granted; saturates at STARVE_LIMIT.
- BUSY_x, no error: drive `mem_addr`/`mem_wdata`/`load_byte`/`store_byte` from the request register; `mem_read = !we`, `mem_write = we`. Store commits at end of BUSY. Load captures `mem_rdata` into the response register at end of BUSY.
- BUSY_x with error: `mem_read = mem_write = 0`, response data 0, err 1.
- RESP: pulse owner's `rvalid` (with `err`, `rdata`), return to IDLE. The other port's rvalid/err stay 0 and its rdata holds its last value.
- Non-owner gnt/rvalid always 0. `mem_read`/`mem_write` are 0 in IDLE and RESP.

## Timing
- Request sampled in IDLE cycle N: gnt in N+1, memory access in N+1 (BUSY), rvalid/rdata in N+2 (RESP), IDLE again in N+3. Peak throughput: one access per 3 cycles.
- The requester drops or changes req in the cycle after seeing gnt. A req still high in RESP is ignored. A req high in IDLE is a new access.
- Simultaneous core and loader req: core wins unless the starvation bound is reached; the loser stays pending and is re-arbitrated in the next IDLE.
- Reset: `mem_read`/`mem_write` are gated combinationally with `rst_n`, so no memory write commits in a reset cycle, even mid-BUSY. After the edge: state IDLE, `starve_cnt` 0, all gnt/rvalid/err 0, rdata 0, mem_* outputs 0. An in-flight access is dropped with no response.
- Range check uses 33-bit arithmetic; no wrap-around (addr 0xFFFFFFFE word is an error).

## Structure
- Shared package `dmem_pkg`: FSM state enum, request struct {we, byte, addr, wdata}, `MEM_BYTES` default.
- Sub-module `dmem_prio_sel`: winner select plus starvation counter. Everything else lives inline.

## Test plan
- Core word store 0xDEADBEEF @0x10, then core word load @0x10 -> gnt at N+1, rvalid at N+2, rdata 0xDEADBEEF, err 0.
- Loader byte store 0x80 @0x20, core lb @0x20 -> rdata 0xFFFFFF80.
- Core and loader req held continuously, STARVE_LIMIT = 4 -> grant order core×4, loader, core×4, loader. No pending loader request is ever lost.
- Core word load @0xFFD (MEM_BYTES 4096) -> mem_read stays 0, rvalid with err 1, rdata 0. Byte load @0xFFF is legal.
- Core store in flight with `rst_n` low during BUSY -> mem_write 0 that cycle, memory unchanged, no rvalid, all outputs 0 after the edge.
- Single req held through RESP -> exactly one gnt and one rvalid per access, no duplicate issue.
